// File: rtl/trg_pls_pkg.sv
// rtl/trg_pls_pkg.sv - shared constants and types for the multi-channel trigger pulse generator
package trg_pls_pkg;

  // Register offsets within a channel (addr[3:0])
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_DELAY  = 4'd1;
  localparam logic [3:0] REG_WIDTH  = 4'd2;
  localparam logic [3:0] REG_PERIOD = 4'd3;

  // Broadcast soft-trigger address; data bit i fires channel i
  localparam logic [7:0] ADDR_SOFT_TRG = 8'hF0;

  // CTRL register bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_INV      = 2;

  // SPI frame: addr[7:0] followed by data[15:0]
  localparam int FRAME_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } ch_state_t;

endpackage

// File: rtl/trg_pls_channel.sv
// rtl/trg_pls_channel.sv - one pulse channel: config registers, sequencing FSM and down-counter
module trg_pls_channel
  import trg_pls_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_reg,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             soft_trg,
  input  logic             ext_rise,
  output logic             trg_pls,
  output logic             busy
);

  logic [2:0]       ctrl;
  logic [CNT_W-1:0] delay_r, width_r, period_r;

  ch_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] w_width, w_period;
  logic             w_periodic;

  logic             ctrl_wr, disable_wr, accept;
  logic [CNT_W-1:0] cur_w, cur_p, low_len;
  logic             cur_per;
  logic             go_high, go_after;
  logic             inv_next, pls_next;

  assign ctrl_wr    = wr_en && (wr_reg == REG_CTRL);
  // Clearing enable wins over a trigger arriving in the same cycle
  assign disable_wr = ctrl_wr && !wr_data[CTRL_EN];
  assign accept     = (state == ST_IDLE) && ctrl[CTRL_EN] && (soft_trg || ext_rise) && !disable_wr;

  // In IDLE the working copies are not loaded yet, so the live registers are used
  assign cur_w   = (state == ST_IDLE) ? width_r  : w_width;
  assign cur_p   = (state == ST_IDLE) ? period_r : w_period;
  assign cur_per = (state == ST_IDLE) ? ctrl[CTRL_PERIODIC] : w_periodic;
  assign low_len = (cur_p > cur_w) ? (cur_p - cur_w) : CNT_W'(1);

  assign busy = (state != ST_IDLE);

  // Configuration registers, written only by committed SPI frames
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      delay_r  <= '0;
      width_r  <= '0;
      period_r <= '0;
    end else if (wr_en) begin
      case (wr_reg)
        REG_CTRL:   ctrl     <= wr_data[2:0];
        REG_DELAY:  delay_r  <= wr_data;
        REG_WIDTH:  width_r  <= wr_data;
        REG_PERIOD: period_r <= wr_data;
        default:    ;
      endcase
    end
  end

  // State register, counter and working copies latched at trigger accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      w_width    <= '0;
      w_period   <= '0;
      w_periodic <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        w_width    <= width_r;
        w_period   <= period_r;
        w_periodic <= ctrl[CTRL_PERIODIC];
      end
    end
  end

  // Next-state logic; zero-length phases fall through to their successor in the same cycle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    go_high    = 1'b0;
    go_after   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (delay_r != '0) begin
            state_next = ST_DELAY;
            cnt_next   = delay_r;
          end else begin
            go_high = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (cnt == CNT_W'(1)) go_high = 1'b1;
        else cnt_next = cnt - CNT_W'(1);
      end
      ST_HIGH: begin
        if (cnt == CNT_W'(1)) go_after = 1'b1;
        else cnt_next = cnt - CNT_W'(1);
      end
      ST_LOW: begin
        if (cnt == CNT_W'(1)) go_high = 1'b1;
        else cnt_next = cnt - CNT_W'(1);
      end
      default: state_next = ST_IDLE;
    endcase
    if (go_high) begin
      if (cur_w != '0) begin
        state_next = ST_HIGH;
        cnt_next   = cur_w;
      end else begin
        go_after = 1'b1;
      end
    end
    if (go_after) begin
      if (cur_per) begin
        state_next = ST_LOW;
        cnt_next   = low_len;
      end else begin
        state_next = ST_IDLE;
      end
    end
    if (disable_wr) state_next = ST_IDLE;
  end

  // Output level for the coming cycle, using the invert bit as it will be after any write
  always_comb begin
    inv_next = ctrl_wr ? wr_data[CTRL_INV] : ctrl[CTRL_INV];
    pls_next = (state_next == ST_HIGH) ^ inv_next;
  end

  // Registered pulse output
  always_ff @(posedge clk) begin
    if (reset) trg_pls <= 1'b0;
    else       trg_pls <= pls_next;
  end

endmodule

// File: rtl/trg_pls_gen_multi.sv
// rtl/trg_pls_gen_multi.sv - SPI-programmed multi-channel trigger pulse generator top
module trg_pls_gen_multi
  import trg_pls_pkg::*;
#(
  parameter int NUM_CH      = 5,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  input  logic [NUM_CH-1:0] ext_trg,
  output logic [NUM_CH-1:0] trg_pls,
  output logic [NUM_CH-1:0] busy,
  output logic              cfg_err
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic [NUM_CH-1:0]      ext_sync [SYNC_STAGES];
  logic                   sclk_d, cs_d;
  logic [NUM_CH-1:0]      ext_d;

  logic                   sclk_s, cs_s, mosi_s;
  logic [NUM_CH-1:0]      ext_s, ext_rise;
  logic                   sclk_rise, cs_fall, cs_rise;

  logic                   in_frame;
  logic [4:0]             bit_cnt;
  logic [FRAME_BITS-1:0]  shift;
  logic                   wr_valid;
  logic [7:0]             wr_addr;
  logic [CNT_W-1:0]       wr_data;

  // Synchronisers plus one delay stage for edge detection; cs resets low so a frame
  // already in progress when reset releases is never seen as starting
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) ext_sync[s] <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      ext_d     <= '0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ext_sync[0] <= ext_trg;
      for (int s = 1; s < SYNC_STAGES; s++) ext_sync[s] <= ext_sync[s-1];
      sclk_d      <= sclk_s;
      cs_d        <= cs_s;
      ext_d       <= ext_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ext_s     = ext_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign ext_rise  = ext_s & ~ext_d;

  // SPI receiver: shift bits during a frame, commit or reject when cs rises
  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      cfg_err  <= 1'b0;
      if (cs_fall) begin
        in_frame <= 1'b1;
        bit_cnt  <= '0;
        shift    <= '0;
      end else if (in_frame && !cs_s && sclk_rise) begin
        shift <= {shift[FRAME_BITS-2:0], mosi_s};
        // Saturate so over-long frames can never alias back to a legal length
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 5'd1;
      end else if (in_frame && cs_rise) begin
        in_frame <= 1'b0;
        if (bit_cnt == 5'(FRAME_BITS)) begin
          wr_valid <= 1'b1;
          wr_addr  <= shift[FRAME_BITS-1 -: 8];
          wr_data  <= shift[CNT_W-1:0];
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_wr, ch_soft;

    assign ch_wr   = wr_valid && (wr_addr[7:4] == 4'(i));
    assign ch_soft = wr_valid && (wr_addr == ADDR_SOFT_TRG) && wr_data[i];

    trg_pls_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (ch_wr),
      .wr_reg   (wr_addr[3:0]),
      .wr_data  (wr_data),
      .soft_trg (ch_soft),
      .ext_rise (ext_rise[i]),
      .trg_pls  (trg_pls[i]),
      .busy     (busy[i])
    );
  end

endmodule
